// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - bit-serial adder/subtractor sequencer
//
// Computes A+B or A-B one bit per clock with a single full-adder cell and a
// carry flop. START is accepted in IDLE or DONE; the result lands in Y/CO on
// the last RUN edge and DONE pulses for one cycle afterwards.
//
// Ports:
//   CLK    rising-edge clock
//   RST    asynchronous active-low reset
//   START  operation request (sampled in IDLE or DONE)
//   SnA    0 = add, 1 = subtract (A-B), sampled with START
//   A, B   WIDTH-bit operands, sampled with START
//   Y      WIDTH-bit result register
//   CO     final carry-out (for subtract, 1 = no borrow)
//   BUSY   high while iterating
//   DONE   one-cycle pulse when Y/CO become valid
module serial_add_sub #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SnA,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic             CO,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] y_sh;
  logic [WIDTH-1:0] y_nxt;
  logic             c;
  logic [CNT_W-1:0] cnt;
  logic             s;
  logic             cn;
  logic             load;
  logic             last;

  // One full-adder cell working on the LSBs of the operand shifters.
  assign s     = a_sh[0] ^ b_sh[0] ^ c;
  assign cn    = (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]));
  assign y_nxt = {s, y_sh[WIDTH-1:1]};
  assign last  = (state == ST_RUN) && (cnt == LAST_CNT);

  // Status outputs decode the state register only, so no input reaches them
  // combinationally.
  assign BUSY = (state == ST_RUN);
  assign DONE = (state == ST_DONE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // START is deliberately not looked at here: requests during RUN are dropped.
        if (last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (START) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      a_sh <= '0;
      b_sh <= '0;
      y_sh <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      Y    <= '0;
      CO   <= 1'b0;
    end else if (load) begin
      // Subtract as A + ~B + 1: invert B and seed the carry with 1.
      a_sh <= A;
      b_sh <= SnA ? ~B : B;
      c    <= SnA;
      cnt  <= '0;
      y_sh <= '0;
    end else if (state == ST_RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      y_sh <= y_nxt;
      c    <= cn;
      cnt  <= cnt + 1'b1;
      if (last) begin
        Y  <= y_nxt;
        CO <= cn;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - directed self-checking bench for serial_add_sub
module tb_serial_add_sub;

  logic        CLK;
  logic        RST;
  logic        START;
  logic        SnA;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Y;
  logic        CO;
  logic        BUSY;
  logic        DONE;

  int errors;
  int checks;

  int done_k;
  int ndone;
  int nbusy;

  serial_add_sub #(.WIDTH(32), .CNT_W(6)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .SnA   (SnA),
    .A     (A),
    .B     (B),
    .Y     (Y),
    .CO    (CO),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one START pulse and watch 40 edges. inject > 0 pulses START with
  // A=B=7 after that edge; abort > 0 asserts reset after that edge.
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                    input int inject, input int abort,
                    output int dk, output int nd, output int nb);
    @(posedge CLK); #1;
    A = a; B = b; SnA = sub; START = 1'b1;
    dk = 0; nd = 0; nb = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge CLK); #1;
      if (k == 1) begin
        START = 1'b0;
        A = ~a;
        B = ~b;
        SnA = ~sub;
      end
      if (inject != 0 && k == inject) begin
        START = 1'b1; A = 32'd7; B = 32'd7;
      end
      if (inject != 0 && k == inject + 1) START = 1'b0;
      if (BUSY) nb++;
      if (DONE) begin
        nd++;
        if (dk == 0) dk = k;
      end
      if (abort != 0 && k == abort) begin
        RST = 1'b0;
        #1;
        check("abort_y",    Y,    64'h0);
        check("abort_co",   CO,   64'h0);
        check("abort_busy", BUSY, 64'h0);
        #3 RST = 1'b1;
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    RST   = 1'b0;
    START = $urandom_range(1, 0);
    SnA   = $urandom_range(1, 0);
    A     = $urandom;
    B     = $urandom;

    // Reset values before any clock edge.
    #1;
    check("rst_y",    Y,    64'h0);
    check("rst_co",   CO,   64'h0);
    check("rst_busy", BUSY, 64'h0);
    check("rst_done", DONE, 64'h0);
    START = 1'b0;
    #11 RST = 1'b1;

    // Add 5+3.
    op(32'd5, 32'd3, 1'b0, 0, 0, done_k, ndone, nbusy);
    check("add1_y",    Y,      64'h8);
    check("add1_co",   CO,     64'h0);
    check("add1_lat",  done_k, 64'd33);
    check("add1_busy", nbusy,  64'd32);
    check("add1_nd",   ndone,  64'd1);

    // Add wrap-around.
    op(32'hFFFF_FFFF, 32'h1, 1'b0, 0, 0, done_k, ndone, nbusy);
    check("add2_y",  Y,  64'h0);
    check("add2_co", CO, 64'h1);

    // Subtracts.
    op(32'd5, 32'd3, 1'b1, 0, 0, done_k, ndone, nbusy);
    check("sub1_y",  Y,  64'h2);
    check("sub1_co", CO, 64'h1);

    op(32'd3, 32'd5, 1'b1, 0, 0, done_k, ndone, nbusy);
    check("sub2_y",  Y,  64'hFFFF_FFFE);
    check("sub2_co", CO, 64'h0);

    op(32'h8000_0000, 32'h1, 1'b1, 0, 0, done_k, ndone, nbusy);
    check("sub3_y",  Y,  64'h7FFF_FFFF);
    check("sub3_co", CO, 64'h1);

    // START during RUN is ignored.
    op(32'd1, 32'd2, 1'b0, 10, 0, done_k, ndone, nbusy);
    check("ign_y",   Y,      64'h3);
    check("ign_co",  CO,     64'h0);
    check("ign_lat", done_k, 64'd33);
    check("ign_nd",  ndone,  64'd1);

    // Back-to-back with START held high; new operands after each DONE.
    @(posedge CLK); #1;
    A = 32'd1; B = 32'd1; SnA = 1'b0; START = 1'b1;
    for (int n = 0; n < 3; n++) begin
      done_k = 0;
      for (int k = 1; k <= 40 && done_k == 0; k++) begin
        @(posedge CLK); #1;
        if (DONE) done_k = k;
      end
      check("b2b_lat", done_k, 64'd33);
      case (n)
        0: begin
          check("b2b0_y",  Y,  64'h2);
          check("b2b0_co", CO, 64'h0);
          A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; SnA = 1'b0;
        end
        1: begin
          check("b2b1_y",  Y,  64'hFFFF_FFFE);
          check("b2b1_co", CO, 64'h1);
          A = 32'd10; B = 32'd20; SnA = 1'b1;
        end
        default: begin
          check("b2b2_y",  Y,  64'hFFFF_FFF6);
          check("b2b2_co", CO, 64'h0);
          START = 1'b0;
        end
      endcase
    end

    // Reset in the middle of an operation.
    op(32'hAAAA_AAAA, 32'h1234_5678, 1'b0, 0, 15, done_k, ndone, nbusy);
    check("abort_nd",   ndone, 64'd0);
    check("abort_y2",   Y,     64'h0);
    check("abort_co2",  CO,    64'h0);

    op(32'h1234_5678, 32'h1111_1111, 1'b0, 0, 0, done_k, ndone, nbusy);
    check("post_y",   Y,      64'h2345_6789);
    check("post_co",  CO,     64'h0);
    check("post_lat", done_k, 64'd33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
